// File: rtl/alu_pkg.sv
// Shared definitions for the iterative RISC-V M-extension multiply/divide unit.
package alu_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Start/busy/done request bundle between the execute stage and the mul/div unit.
interface alu_muldiv_if #(
    parameter int unsigned XLEN = 64
) ();

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] InputA;
    logic [XLEN-1:0] InputB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] OutMulDiv;

    modport master (
        output start, op, InputA, InputB,
        input  busy, done, OutMulDiv
    );

    modport slave (
        input  start, op, InputA, InputB,
        output busy, done, OutMulDiv
    );

endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module muldiv_signfix #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] res_c
);

    assign res_c = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply / restoring divide for RISC-V M ops, one bit per cycle.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic       clk,
    input  logic       reset,
    alu_muldiv_if.slave bus
);

    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam int unsigned PW = 2 * XLEN;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            in_sa, in_sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] spec_res;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift, div_diff;
    logic            div_ge;
    logic [PW-1:0]   fix_in, fix_out;
    logic            fix_neg;
    logic [XLEN-1:0] fix_res;

    // Operand signs: A is signed for mulh/mulhsu/div/rem, B for mulh/div/rem.
    assign in_sa = ((bus.op == MULH) || (bus.op == MULHSU) || (bus.op == DIV) || (bus.op == REM))
                   && bus.InputA[XLEN-1];
    assign in_sb = ((bus.op == MULH) || (bus.op == DIV) || (bus.op == REM)) && bus.InputB[XLEN-1];

    muldiv_signfix #(.W(XLEN)) u_abs_a (.value(bus.InputA), .neg(in_sa), .res_c(abs_a));
    muldiv_signfix #(.W(XLEN)) u_abs_b (.value(bus.InputB), .neg(in_sb), .res_c(abs_b));

    assign div_zero = is_div(bus.op) && (bus.InputB == '0);
    assign div_ovf  = ((bus.op == DIV) || (bus.op == REM))
                      && (bus.InputA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.InputB == '1);

    // Early-exit results for divide-by-zero and signed overflow.
    always_comb begin
        spec_res = '0;
        if (div_zero) begin
            spec_res = is_rem(bus.op) ? bus.InputA : '1;
        end else begin
            spec_res = is_rem(bus.op) ? '0 : bus.InputA;
        end
    end

    // Shift-add step: accumulator lives in the upper half, multiplier shifts out of the lower.
    assign mul_sum = {1'b0, prod_q[PW-1:XLEN]} + {1'b0, opb_q & {XLEN{prod_q[0]}}};

    // Restoring step; the borrow bit of the XLEN+1 bit trial subtract is the compare.
    assign div_shift = {rem_q, prod_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = ~div_diff[XLEN];

    always_comb begin
        fix_in  = prod_q;
        fix_neg = sign_a_q ^ sign_b_q;
        if (is_rem(op_q)) begin
            fix_in  = {{XLEN{1'b0}}, rem_q};
            fix_neg = sign_a_q;
        end else if (is_div(op_q)) begin
            fix_in  = {{XLEN{1'b0}}, prod_q[XLEN-1:0]};
        end
    end

    muldiv_signfix #(.W(PW)) u_fix (.value(fix_in), .neg(fix_neg), .res_c(fix_out));

    assign fix_res = ((op_q == MUL) || is_div(op_q)) ? fix_out[XLEN-1:0] : fix_out[PW-1:XLEN];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        out_d    = out_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    sign_a_d = in_sa;
                    sign_b_d = in_sb;
                    cnt_d    = CW'(XLEN);
                    opb_d    = abs_b;
                    rem_d    = '0;
                    prod_d   = {{XLEN{1'b0}}, abs_a};
                    state_d  = CALC;
                    if (div_zero || div_ovf) begin
                        out_d   = spec_res;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div(op_q)) begin
                    rem_d  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                    prod_d = {prod_q[PW-1:XLEN], prod_q[XLEN-2:0], div_ge};
                end else begin
                    prod_d = {mul_sum, prod_q[XLEN-1:1]};
                end
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                out_d   = fix_res;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opb_q    <= opb_d;
            rem_q    <= rem_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.OutMulDiv = out_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed checks of alu_muldiv at XLEN=64 and XLEN=32 with hand-computed results.
module tb_alu_muldiv;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu_muldiv_if #(.XLEN(64)) b64 ();
    alu_muldiv_if #(.XLEN(32)) b32 ();

    alu_muldiv #(.XLEN(64)) u_dut64 (.clk(clk), .reset(reset), .bus(b64));
    alu_muldiv #(.XLEN(32)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        string       tag;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op on the 64-bit unit; optionally re-pulse start at cycle 'poke'.
    task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input int poke, output logic [63:0] res, output int lat,
                         output bit busy_ok);
        @(negedge clk);
        b64.start = 1'b1; b64.op = op; b64.InputA = a; b64.InputB = b;
        @(posedge clk); #1;
        b64.start = 1'b0; b64.op = MUL; b64.InputA = '0; b64.InputB = '0;
        lat = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            if (b64.done) begin
                lat = c;
                break;
            end
            if (!b64.busy) busy_ok = 1'b0;
            if (c == poke) begin
                b64.start = 1'b1; b64.op = DIVU; b64.InputA = 64'd5; b64.InputB = 64'd0;
            end else begin
                b64.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        b64.start = 1'b0;
        res = b64.OutMulDiv;
        check("busy_at_done", 64'(b64.busy), 64'd0);
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        bit          bok;
        int          n_done;

        vecs[0]  = '{MUL,    64'd7,                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, "mul_7_m3"};
        vecs[1]  = '{MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 66, "mulh_min"};
        vecs[2]  = '{MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66, "mulhu_ones"};
        vecs[3]  = '{MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFF, 66, "mulhsu_m1_2"};
        vecs[4]  = '{DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFD, 66, "div_m7_2"};
        vecs[5]  = '{REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFF, 66, "rem_m7_2"};
        vecs[6]  = '{DIVU,   64'd100,               64'd7,                 64'd14,                  66, "divu_100_7"};
        vecs[7]  = '{REMU,   64'd100,               64'd7,                 64'd2,                   66, "remu_100_7"};
        vecs[8]  = '{DIV,    64'd7,                 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66, "div_7_m2"};
        vecs[9]  = '{REM,    64'd7,                 64'hFFFF_FFFF_FFFF_FFFE, 64'd1,                   66, "rem_7_m2"};
        vecs[10] = '{DIVU,   64'd5,                 64'd0,                 64'hFFFF_FFFF_FFFF_FFFF, 1,  "divu_by0"};
        vecs[11] = '{REMU,   64'd5,                 64'd0,                 64'd5,                   1,  "remu_by0"};
        vecs[12] = '{DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1,  "div_ovf"};
        vecs[13] = '{REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   1,  "rem_ovf"};
        vecs[14] = '{REM,    64'hFFFF_FFFF_FFFF_FFFB, 64'd0,                 64'hFFFF_FFFF_FFFF_FFFB, 1,  "rem_m5_by0"};
        vecs[15] = '{MULH,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFF, 66, "mulh_m7_2"};

        reset = 1'b1;
        b64.start = 1'b0; b64.op = MUL; b64.InputA = '0; b64.InputB = '0;
        b32.start = 1'b0; b32.op = MUL; b32.InputA = '0; b32.InputB = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy64", 64'(b64.busy), 64'd0);
        check("rst_done64", 64'(b64.done), 64'd0);
        check("rst_out64",  b64.OutMulDiv, 64'd0);
        check("rst_busy32", 64'(b32.busy), 64'd0);
        check("rst_done32", 64'(b32.done), 64'd0);
        check("rst_out32",  64'(b32.OutMulDiv), 64'd0);

        // First op alone, then confirm the done pulse is a single cycle.
        run64(vecs[0].op, vecs[0].a, vecs[0].b, 0, res, lat, bok);
        check("mul_res", res, vecs[0].exp);
        check("mul_lat", 64'(lat), 64'd66);
        check("mul_busy", 64'(bok), 64'd1);
        @(posedge clk); #1;
        check("done_single", 64'(b64.done), 64'd0);

        for (int i = 1; i < 16; i++) begin
            run64(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat, bok);
            check({vecs[i].tag, "_res"}, res, vecs[i].exp);
            check({vecs[i].tag, "_lat"}, 64'(lat), 64'(vecs[i].lat));
            check({vecs[i].tag, "_busy"}, 64'(bok), 64'd1);
        end

        // A start pulsed mid-operation must be ignored.
        run64(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 10, res, lat, bok);
        check("poke_res", res, 64'hFFFF_FFFF_FFFF_FFEB);
        check("poke_lat", 64'(lat), 64'd66);
        check("poke_busy", 64'(bok), 64'd1);

        // Reset in cycle 30 of a running mul discards it.
        @(negedge clk);
        b64.start = 1'b1; b64.op = MUL; b64.InputA = 64'd7; b64.InputB = 64'd3;
        @(posedge clk); #1;
        b64.start = 1'b0;
        for (int c = 1; c < 30; c++) begin
            @(posedge clk); #1;
        end
        check("busy_c30", 64'(b64.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_busy", 64'(b64.busy), 64'd0);
        check("rst_mid_done", 64'(b64.done), 64'd0);
        check("rst_mid_out",  b64.OutMulDiv, 64'd0);
        n_done = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (b64.done) n_done++;
        end
        check("rst_no_done", 64'(n_done), 64'd0);

        run64(DIVU, 64'd100, 64'd7, 0, res, lat, bok);
        check("post_rst_res", res, 64'd14);
        check("post_rst_lat", 64'(lat), 64'd66);

        // 32-bit instance.
        @(negedge clk);
        b32.start = 1'b1; b32.op = MUL; b32.InputA = 32'hFFFF_FFFF; b32.InputB = 32'd2;
        @(posedge clk); #1;
        b32.start = 1'b0; b32.InputA = '0; b32.InputB = '0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (b32.done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        check("mul32_res", 64'(b32.OutMulDiv), 64'h0000_0000_FFFF_FFFE);
        check("mul32_lat", 64'(lat), 64'd34);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
